// File: rtl/unified_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : unified_mem_arbiter
// Purpose  : Shares one single-port, variable-latency memory between the
//            instruction-fetch stage and the data-memory stage of the MIPS
//            pipeline. Data accesses have priority. Each grant is latched and
//            the memory handshake is driven from those latched fields. A
//            one-cycle done pulse returns the read data, and the stall_*
//            outputs let the pipeline controller freeze IF or MEM.
// Revision : 1.0 - initial release
// Options  : ARB_STARVE_GUARD_EN - when defined, fetch is guaranteed a grant
//            after MAX_D_STREAK consecutive data grants made while it waited.
// Ports    :
//   clk, rst_n                     clock (rising edge), async active-low reset
//   if_req/if_addr/if_cancel       fetch request, address, flush
//   if_done/if_rdata               fetch completion pulse and fetched word
//   d_req/d_we/d_addr/d_wdata      data request (sw when d_we=1, else lw)
//   d_done/d_rdata                 data completion pulse and load word
//   mem_req/mem_we/mem_addr/
//   mem_wdata/mem_rdata/mem_ack    memory handshake
//   stall_if, stall_mem            combinational freeze requests
// ============================================================================
module unified_mem_arbiter #(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int MAX_D_STREAK = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  input  logic          if_cancel,
  output logic          if_done,
  output logic [DW-1:0] if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_done,
  output logic [DW-1:0] d_rdata,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  output logic          stall_if,
  output logic          stall_mem
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          owner_if_q, owner_if_d;   // 1 = fetch owns the access
  logic          cancel_q, cancel_d;       // fetch was flushed during ACC
  logic          mem_req_q, mem_req_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          if_done_q, if_done_d;
  logic          d_done_q, d_done_d;
  logic [DW-1:0] if_rdata_q, if_rdata_d;
  logic [DW-1:0] d_rdata_q, d_rdata_d;

  logic          if_elig;
  logic          guard_force;
  logic          grant_if;

  // A flushed fetch is never eligible for a grant.
  assign if_elig = if_req & ~if_cancel;

`ifdef ARB_STARVE_GUARD_EN
  localparam int unsigned             STREAK_W   = $clog2(MAX_D_STREAK + 1);
  localparam logic [STREAK_W-1:0]     STREAK_MAX = STREAK_W'(MAX_D_STREAK);

  logic [STREAK_W-1:0] streak_q, streak_d;

  assign guard_force = (streak_q == STREAK_MAX) & d_req & if_elig;
`else
  // Strict data priority; the parameter only matters when the guard exists.
  logic unused_max_d_streak;
  assign unused_max_d_streak = |MAX_D_STREAK;
  assign guard_force         = 1'b0;
`endif

  assign grant_if = if_elig & (~d_req | guard_force);

  always_comb begin
    state_d     = state_q;
    owner_if_d  = owner_if_q;
    cancel_d    = cancel_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_done_d   = 1'b0;
    d_done_d    = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
`ifdef ARB_STARVE_GUARD_EN
    streak_d    = streak_q;
`endif
    case (state_q)
      IDLE: begin
`ifdef ARB_STARVE_GUARD_EN
        if (!if_req) begin
          streak_d = '0;
        end
`endif
        if (if_elig || d_req) begin
          state_d    = ACC;
          owner_if_d = grant_if;
          cancel_d   = 1'b0;
          mem_req_d  = 1'b1;
          if (grant_if) begin
            // Fetch is a read; store data register keeps its old value.
            mem_we_d   = 1'b0;
            mem_addr_d = if_addr;
`ifdef ARB_STARVE_GUARD_EN
            streak_d   = '0;
`endif
          end else begin
            mem_we_d    = d_we;
            mem_addr_d  = d_addr;
            mem_wdata_d = d_wdata;
`ifdef ARB_STARVE_GUARD_EN
            if (if_elig && (streak_q != STREAK_MAX)) begin
              streak_d = streak_q + STREAK_W'(1);
            end
`endif
          end
        end
      end
      ACC: begin
        if (owner_if_q && if_cancel) begin
          cancel_d = 1'b1;
        end
        if (mem_ack) begin
          state_d   = RESP;
          mem_req_d = 1'b0;
          if (owner_if_q) begin
            if_rdata_d = mem_rdata;
            if_done_d  = ~(cancel_q | if_cancel);
          end else begin
            d_done_d = 1'b1;
            if (!mem_we_q) begin
              d_rdata_d = mem_rdata;
            end
          end
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      owner_if_q  <= 1'b0;
      cancel_q    <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_done_q   <= 1'b0;
      d_done_q    <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
`ifdef ARB_STARVE_GUARD_EN
      streak_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      owner_if_q  <= owner_if_d;
      cancel_q    <= cancel_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_done_q   <= if_done_d;
      d_done_q    <= d_done_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
`ifdef ARB_STARVE_GUARD_EN
      streak_q    <= streak_d;
`endif
    end
  end

  // A flush arriving during RESP kills the pulse in that same cycle.
  assign if_done   = if_done_q & ~if_cancel;
  assign d_done    = d_done_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

  assign stall_if  = if_req & ~if_done & ~if_cancel;
  assign stall_mem = d_req & ~d_done;

endmodule
`default_nettype wire

// File: tb/tb_unified_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_unified_mem_arbiter
// Purpose  : Directed self-checking bench for unified_mem_arbiter. Expected
//            values are hand-computed per scenario; guard expectations follow
//            ARB_STARVE_GUARD_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_unified_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, if_cancel, d_req, d_we, mem_ack;
  logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
  logic        if_done, d_done, mem_req, mem_we, stall_if, stall_mem;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  unified_mem_arbiter #(.AW(32), .DW(32), .MAX_D_STREAK(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_cancel(if_cancel),
    .if_done(if_done), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_done(d_done), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .stall_if(stall_if), .stall_mem(stall_mem)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for mem_req, records the latched request, acks after
  // lat cycles and returns with the arbiter in its RESP cycle.
  task automatic run_access(input int lat, input logic [31:0] rd,
                            output logic [31:0] addr, output logic we);
    int n = 0;
    while (mem_req !== 1'b1 && n < 8) begin
      tick();
      n++;
    end
    tests++;
    if (mem_req !== 1'b1) begin
      fails++;
      $display("FAIL grant_timeout: mem_req=%b required 1", mem_req);
    end
    addr = mem_addr;
    we   = mem_we;
    repeat (lat - 1) tick();
    mem_ack = 1'b1; mem_rdata = rd;
    tick();
    mem_ack = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    if_req = 0; if_cancel = 0; d_req = 0; d_we = 0; mem_ack = 0;
    if_addr = 0; d_addr = 0; d_wdata = 0; mem_rdata = 0;
    repeat (2) @(posedge clk);
    #1;
    tests++; if ({mem_req, mem_we, if_done, d_done} !== 4'b0) begin fails++; $display("FAIL reset_ctrl: got %b required 0000", {mem_req, mem_we, if_done, d_done}); end
    tests++; if ({mem_addr, mem_wdata, if_rdata, d_rdata} !== 128'd0) begin fails++; $display("FAIL reset_data: got %h required 0", {mem_addr, mem_wdata, if_rdata, d_rdata}); end
    rst_n = 1'b1;
    tick();
    // A stray ack in IDLE must do nothing.
    mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    tick();
    mem_ack = 1'b0;
    tick();
    tests++; if ({mem_req, if_done, d_done} !== 3'b0 || d_rdata !== 32'd0) begin fails++; $display("FAIL stray_ack: ctrl=%b d_rdata=%h required 000/0", {mem_req, if_done, d_done}, d_rdata); end
  endtask

  task automatic test_single_fetch;
    if_req = 1; if_addr = 32'h40;                      // cycle 0
    tick();                                            // cycle 1
    tests++; if (mem_req !== 1'b1 || mem_addr !== 32'h40 || mem_we !== 1'b0) begin fails++; $display("FAIL fetch_grant: req=%b addr=%h we=%b required 1/40/0", mem_req, mem_addr, mem_we); end
    tests++; if (stall_if !== 1'b1) begin fails++; $display("FAIL fetch_stall: got %b required 1", stall_if); end
    tick();                                            // cycle 2
    mem_ack = 1; mem_rdata = 32'h2010_0005;
    tick();                                            // cycle 3
    mem_ack = 0;
    tests++; if (if_done !== 1'b1 || if_rdata !== 32'h2010_0005) begin fails++; $display("FAIL fetch_done: done=%b rdata=%h required 1/20100005", if_done, if_rdata); end
    tests++; if (stall_if !== 1'b0 || mem_req !== 1'b0 || d_done !== 1'b0) begin fails++; $display("FAIL fetch_resp: stall=%b req=%b d_done=%b required 000", stall_if, mem_req, d_done); end
    if_req = 0;
    tick();                                            // cycle 4
    tests++; if (if_done !== 1'b0 || stall_if !== 1'b0 || if_rdata !== 32'h2010_0005) begin fails++; $display("FAIL fetch_after: done=%b stall=%b rdata=%h required 0/0/20100005", if_done, stall_if, if_rdata); end
  endtask

  task automatic test_cancel_resp;
    logic [31:0] a; logic w;
    if_req = 1; if_addr = 32'h44;
    tick();
    run_access(1, 32'h1111_2222, a, w);
    tests++; if (if_done !== 1'b1) begin fails++; $display("FAIL resp_done: got %b required 1", if_done); end
    if_cancel = 1;
    #1;
    tests++; if (if_done !== 1'b0) begin fails++; $display("FAIL resp_cancel: if_done=%b required 0", if_done); end
    if_req = 0;
    tick();
    if_cancel = 0;
    tick();
  endtask

  task automatic test_contention;
    logic [31:0] a; logic w;
    if_req = 1; if_addr = 32'h40;
    d_req = 1; d_we = 0; d_addr = 32'h100;
    tick();
    run_access(1, 32'h1234_5678, a, w);
    tests++; if (a !== 32'h100 || w !== 1'b0) begin fails++; $display("FAIL contend_first: addr=%h we=%b required 100/0", a, w); end
    tests++; if (d_done !== 1'b1 || d_rdata !== 32'h1234_5678 || if_done !== 1'b0) begin fails++; $display("FAIL contend_ddone: d_done=%b d_rdata=%h if_done=%b required 1/12345678/0", d_done, d_rdata, if_done); end
    tests++; if (stall_mem !== 1'b0 || stall_if !== 1'b1) begin fails++; $display("FAIL contend_stall: mem=%b if=%b required 0/1", stall_mem, stall_if); end
    d_req = 0;
    tick();                                            // IDLE
    tick();                                            // fetch ACC
    tests++; if (mem_req !== 1'b1 || mem_addr !== 32'h40) begin fails++; $display("FAIL contend_second: req=%b addr=%h required 1/40", mem_req, mem_addr); end
    run_access(2, 32'h0BAD_F00D, a, w);
    tests++; if (if_done !== 1'b1 || if_rdata !== 32'h0BAD_F00D) begin fails++; $display("FAIL contend_idone: done=%b rdata=%h required 1/0badf00d", if_done, if_rdata); end
    if_req = 0;
    tick();
  endtask

  task automatic test_store;
    logic [31:0] a; logic w;
    d_req = 1; d_we = 1; d_addr = 32'h8; d_wdata = 32'hDEAD_BEEF;
    tick();
    tests++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h8 || mem_wdata !== 32'hDEAD_BEEF) begin fails++; $display("FAIL store_latch: req=%b we=%b addr=%h wdata=%h required 1/1/8/deadbeef", mem_req, mem_we, mem_addr, mem_wdata); end
    d_wdata = 32'h0;                                   // latched copy must hold
    tick();
    tests++; if (mem_wdata !== 32'hDEAD_BEEF || mem_req !== 1'b1) begin fails++; $display("FAIL store_hold: wdata=%h req=%b required deadbeef/1", mem_wdata, mem_req); end
    run_access(1, 32'hFFFF_0000, a, w);
    tests++; if (d_done !== 1'b1 || d_rdata !== 32'h1234_5678) begin fails++; $display("FAIL store_done: d_done=%b d_rdata=%h required 1/12345678", d_done, d_rdata); end
    d_req = 0; d_we = 0;
    tick();
    tests++; if (d_done !== 1'b0) begin fails++; $display("FAIL store_pulse: d_done=%b required 0", d_done); end
    // A following fetch clears mem_we but keeps the store data register.
    if_req = 1; if_addr = 32'h48;
    tick();
    tests++; if (mem_we !== 1'b0 || mem_wdata !== 32'hDEAD_BEEF || mem_addr !== 32'h48) begin fails++; $display("FAIL fetch_wdata: we=%b wdata=%h addr=%h required 0/deadbeef/48", mem_we, mem_wdata, mem_addr); end
    run_access(1, 32'h5, a, w);
    if_req = 0;
    tick();
  endtask

  task automatic test_cancel_acc;
    if_req = 1; if_addr = 32'h80;                      // cycle 0
    tick();                                            // cycle 1: ACC
    if_cancel = 1;
    #1;
    tests++; if (stall_if !== 1'b0) begin fails++; $display("FAIL cancel_stall: got %b required 0", stall_if); end
    tick();                                            // cycle 2
    if_cancel = 0; if_req = 0;
    tests++; if (mem_req !== 1'b1) begin fails++; $display("FAIL cancel_hold2: mem_req=%b required 1", mem_req); end
    tick();                                            // cycle 3
    tests++; if (mem_req !== 1'b1) begin fails++; $display("FAIL cancel_hold3: mem_req=%b required 1", mem_req); end
    tick();                                            // cycle 4
    tests++; if (mem_req !== 1'b1 || if_done !== 1'b0) begin fails++; $display("FAIL cancel_hold4: mem_req=%b if_done=%b required 1/0", mem_req, if_done); end
    mem_ack = 1; mem_rdata = 32'h7777_7777;
    tick();                                            // cycle 5: RESP
    mem_ack = 0;
    tests++; if (if_done !== 1'b0 || mem_req !== 1'b0) begin fails++; $display("FAIL cancel_nodone: if_done=%b mem_req=%b required 0/0", if_done, mem_req); end
    tick();                                            // cycle 6: IDLE
    tick();                                            // cycle 7: still IDLE
    tests++; if (mem_req !== 1'b0 || if_done !== 1'b0) begin fails++; $display("FAIL cancel_idle: mem_req=%b if_done=%b required 0/0", mem_req, if_done); end
  endtask

  task automatic test_starvation;
    logic [31:0] a; logic w;
    logic exp_fetch [6];
`ifdef ARB_STARVE_GUARD_EN
    exp_fetch = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
`else
    exp_fetch = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`endif
    if_req = 1; if_addr = 32'h40;
    d_req = 1; d_we = 0; d_addr = 32'h200;
    for (int g = 0; g < 6; g++) begin
      run_access(1, 32'(g), a, w);
      tests++; if ((a == 32'h40) !== exp_fetch[g]) begin fails++; $display("FAIL starve_grant%0d: addr=%h fetch_expected=%b", g, a, exp_fetch[g]); end
      tick();
    end
    if_req = 0; d_req = 0;
    tick();
    tick();
  endtask

  task automatic test_reset_mid_acc;
    logic [31:0] a; logic w;
    d_req = 1; d_we = 0; d_addr = 32'h300;
    tick();
    tests++; if (mem_req !== 1'b1) begin fails++; $display("FAIL rst_pre: mem_req=%b required 1", mem_req); end
    #2 rst_n = 1'b0;
    #1;
    tests++; if ({mem_req, if_done, d_done} !== 3'b0 || mem_addr !== 32'd0) begin fails++; $display("FAIL rst_mid: ctrl=%b addr=%h required 000/0", {mem_req, if_done, d_done}, mem_addr); end
    d_req = 0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    tests++; if ({mem_req, d_done} !== 2'b0) begin fails++; $display("FAIL rst_after: ctrl=%b required 00", {mem_req, d_done}); end
    d_req = 1; d_addr = 32'h304;
    tick();
    run_access(2, 32'hCAFE_0001, a, w);
    tests++; if (a !== 32'h304 || d_done !== 1'b1 || d_rdata !== 32'hCAFE_0001) begin fails++; $display("FAIL rst_regrant: addr=%h d_done=%b d_rdata=%h required 304/1/cafe0001", a, d_done, d_rdata); end
    d_req = 0;
    tick();
    tests++; if (d_done !== 1'b0) begin fails++; $display("FAIL rst_regrant_pulse: d_done=%b required 0", d_done); end
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_cancel_resp();
    test_contention();
    test_store();
    test_cancel_acc();
    test_starvation();
    test_reset_mid_acc();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
